trojan_response_checker: RTL and testbench
==========================================

Name: trojan_response_checker

Overview:
- Receiving end of the exhaustive-sweep flow: a bench or on-chip sequencer applies all 2^N_IN input patterns to a DUT, and this block consumes the resulting (pattern, response) stream.
- The block holds a golden-response table loaded beforehand and compares each observed response against it.
- It tracks pattern coverage, counts mismatches, captures the first failing pattern, and raises a sticky trojan flag.

Parameters:
- N_IN, 3, pattern width; the table holds 2^N_IN entries.
- N_OUT, 1, response width per pattern.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; accepted in IDLE or DONE; moves to LOAD.
- ld_valid  input  1  golden entry valid.
- ld_ready  output  1  high only in LOAD.
- ld_addr  input  N_IN  golden entry pattern index.
- ld_data  input  N_OUT  expected response.
- ld_last  input  1  marks the final load beat.
- obs_valid  input  1  observed pair valid.
- obs_ready  output  1  high only in CHECK.
- obs_pattern  input  N_IN  applied pattern.
- obs_resp  input  N_OUT  DUT response.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  high in DONE.
- trojan_flag  output  1  sticky; set on any mismatch.
- mismatch_count  output  N_IN+1  saturating count of mismatches.
- coverage_count  output  N_IN+1  number of distinct patterns checked.
- first_bad_valid  output  1  first_bad_pattern holds valid data.
- first_bad_pattern  output  N_IN  pattern of the first mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Table contents are undefined and not cleared.
  - Coverage bitmap cleared.
- FSM states: IDLE, LOAD, CHECK, DONE.
- IDLE/DONE + start=1 -> LOAD.
  - On entry to LOAD: clear mismatch_count, coverage_count, bitmap, trojan_flag and first_bad_*.
  - The table is retained.
- LOAD:
  - Each cycle with ld_valid&&ld_ready writes table[ld_addr]=ld_data.
  - A repeated address overwrites (last write wins).
  - A handshake with ld_last=1 writes the entry, then next state = CHECK.
  - Entries never written are compared against their stale or reset value; this is not checked by the block.
- CHECK:
  - Accept a pair when obs_valid&&obs_ready.
  - Compare obs_resp against table[obs_pattern] combinationally; results register on the same edge.
  - Statistics update 1 cycle after the handshake edge is visible on outputs; there is no backpressure other than state.
  - Mismatch:
    - mismatch_count += 1, saturating at 2^(N_IN+1)-1.
    - trojan_flag <= 1.
    - If first_bad_valid==0, capture first_bad_pattern and set first_bad_valid. Later mismatches never overwrite.
  - Coverage: if bitmap[obs_pattern]==0, set the bit and increment coverage_count.
  - Duplicate pattern: compared again and can count again, but coverage is unchanged.
  - When the accepted pair makes coverage_count reach 2^N_IN, next state = DONE in the same edge.
  - obs_ready drops in DONE, so no pair is accepted after the final one.
- DONE:
  - All statistics hold; done=1.
  - Inputs other than start are ignored.
- start in LOAD or CHECK is ignored; there is no abort except reset.
- A handshake while in the wrong state (ld_valid in CHECK, obs_valid in LOAD) is ignored and has no effect.
- Reset mid-LOAD or mid-CHECK returns immediately to IDLE with cleared statistics.
  - A subsequent start re-enters LOAD and the table must be reloaded to be trusted.
- Table: 2^N_IN x N_OUT registers. Write port is LOAD only; read port is combinational in CHECK.

Test Plan (N_IN=3, N_OUT=1):
- Golden match:
  - Stimulus: load table = pattern parity (addr 0..7, ld_last on 7), then feed patterns 000..111 with matching responses.
  - Required: done=1 one cycle after the 8th handshake; mismatch_count=0; trojan_flag=0; coverage_count=8.
- Single trojan:
  - Stimulus: same load, but the response for 101 is inverted.
  - Required: trojan_flag=1; mismatch_count=1; first_bad_pattern=101; first_bad_valid=1; done after 8 pairs.
- Duplicates and multiple errors:
  - Stimulus: sequence 010(bad), 010(bad), 011(bad), then the remaining 6 correct.
  - Required: mismatch_count=3; first_bad_pattern=010; coverage_count=8; 9 handshakes total before done.
- Wrong-phase traffic:
  - Stimulus: obs_valid asserted during LOAD; ld_valid asserted during CHECK.
  - Required: obs_ready=0 and ld_ready=0 respectively; table and statistics unchanged.
- Reset mid-check:
  - Stimulus: reset=0 after 4 pairs, one of them bad.
  - Required: state IDLE asynchronously; all outputs 0. After a restart with all-good data, trojan_flag=0.
- Restart from DONE:
  - Stimulus: start pulse with ld_last on the first beat, then 8 correct pairs.
  - Required: statistics cleared on entry to LOAD; table retained except the rewritten entry; done again with mismatch_count=0.

Source files
------------

// File: rtl/trojan_response_checker_if.sv
// Purpose: handshake/bus bundle between a sweep sequencer and the response checker.
// Latency: n/a (wires only).
// Backpressure: ld_ready / obs_ready are driven by the checker and are phase-gated, not flow-gated.
// Ports: start; load channel ld_valid/ld_ready/ld_addr/ld_data/ld_last; observe channel
//        obs_valid/obs_ready/obs_pattern/obs_resp; status busy/done/trojan_flag/mismatch_count/
//        coverage_count/first_bad_valid/first_bad_pattern.
interface trojan_response_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
);
    logic              start;
    logic              ld_valid;
    logic              ld_ready;
    logic [N_IN-1:0]   ld_addr;
    logic [N_OUT-1:0]  ld_data;
    logic              ld_last;
    logic              obs_valid;
    logic              obs_ready;
    logic [N_IN-1:0]   obs_pattern;
    logic [N_OUT-1:0]  obs_resp;
    logic              busy;
    logic              done;
    logic              trojan_flag;
    logic [N_IN:0]     mismatch_count;
    logic [N_IN:0]     coverage_count;
    logic              first_bad_valid;
    logic [N_IN-1:0]   first_bad_pattern;

    // Sequencer side.
    modport master (
        output start, ld_valid, ld_addr, ld_data, ld_last,
               obs_valid, obs_pattern, obs_resp,
        input  ld_ready, obs_ready, busy, done, trojan_flag,
               mismatch_count, coverage_count, first_bad_valid, first_bad_pattern
    );

    // Checker side.
    modport slave (
        input  start, ld_valid, ld_addr, ld_data, ld_last,
               obs_valid, obs_pattern, obs_resp,
        output ld_ready, obs_ready, busy, done, trojan_flag,
               mismatch_count, coverage_count, first_bad_valid, first_bad_pattern
    );
endinterface

// File: rtl/trojan_response_checker.sv
// Purpose: compare an exhaustive (pattern, response) sweep against a preloaded golden table.
// Latency: statistics visible 1 cycle after the observe handshake edge; done in the same update.
// Backpressure: none beyond phase; ld_ready only in LOAD, obs_ready only in CHECK.
// Ports: CK (rising-edge clock), reset (async active-low), bus (slave modport of
//        trojan_response_checker_if carrying start, load/observe channels and status outputs).
module trojan_response_checker #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) (
    input  logic                      CK,
    input  logic                      reset,
    trojan_response_checker_if.slave  bus
);
    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = N_IN + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t            state_q;
    logic [N_OUT-1:0]  table_q [DEPTH];
    logic [DEPTH-1:0]  bitmap_q;
    logic              ld_ready_q;
    logic              obs_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              flag_q;
    logic              fbv_q;
    logic [N_IN-1:0]   fbp_q;
    logic [CW-1:0]     mis_q;
    logic [CW-1:0]     cov_q;

    logic              ld_fire;
    logic              obs_fire;
    logic              mismatch;
    logic              new_pat;
    logic [CW-1:0]     cov_d;
    logic [CW-1:0]     mis_d;

    // Ready flags are registered copies of the state, so they double as phase gates.
    assign ld_fire  = bus.ld_valid  && ld_ready_q;
    assign obs_fire = bus.obs_valid && obs_ready_q;
    assign mismatch = bus.obs_resp != table_q[bus.obs_pattern];
    assign new_pat  = !bitmap_q[bus.obs_pattern];
    assign cov_d    = cov_q + CW'(new_pat);
    assign mis_d    = (mis_q == '1) ? mis_q : mis_q + CW'(1);

    // Golden table is deliberately not reset: contents survive reset and restarts.
    always_ff @(posedge CK) begin
        if (ld_fire) begin
            table_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bitmap_q    <= '0;
            ld_ready_q  <= 1'b0;
            obs_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flag_q      <= 1'b0;
            fbv_q       <= 1'b0;
            fbp_q       <= '0;
            mis_q       <= '0;
            cov_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q     <= S_LOAD;
                        ld_ready_q  <= 1'b1;
                        obs_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        bitmap_q    <= '0;
                        flag_q      <= 1'b0;
                        fbv_q       <= 1'b0;
                        fbp_q       <= '0;
                        mis_q       <= '0;
                        cov_q       <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_fire && bus.ld_last) begin
                        state_q     <= S_CHECK;
                        ld_ready_q  <= 1'b0;
                        obs_ready_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (obs_fire) begin
                        if (mismatch) begin
                            mis_q  <= mis_d;
                            flag_q <= 1'b1;
                            // Only the first failure is kept for debug.
                            if (!fbv_q) begin
                                fbv_q <= 1'b1;
                                fbp_q <= bus.obs_pattern;
                            end
                        end
                        if (new_pat) begin
                            bitmap_q[bus.obs_pattern] <= 1'b1;
                            cov_q                     <= cov_d;
                        end
                        // Finish on the handshake that completes coverage, so no
                        // further pair can be accepted.
                        if (cov_d == CW'(DEPTH)) begin
                            state_q     <= S_DONE;
                            obs_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready          = ld_ready_q;
    assign bus.obs_ready         = obs_ready_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.trojan_flag       = flag_q;
    assign bus.mismatch_count    = mis_q;
    assign bus.coverage_count    = cov_q;
    assign bus.first_bad_valid   = fbv_q;
    assign bus.first_bad_pattern = fbp_q;
endmodule

// File: tb/tb_trojan_response_checker.sv
// Purpose: scoreboard bench for trojan_response_checker (N_IN=3, N_OUT=1).
// Latency: expects statistics one cycle after each observe handshake.
// Backpressure: stimulus only drives observe beats in CHECK; monitor pops on every handshake.
module tb_trojan_response_checker;
    localparam int N_IN  = 3;
    localparam int N_OUT = 1;

    logic CK    = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    trojan_response_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    trojan_response_checker #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .CK    (CK),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int mis;
        int cov;
        int flag;
        int fbv;
        int fbp;
        int done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state.
    int m_tab [8];
    bit m_bm  [8];
    int m_mis, m_cov, m_flag, m_fbv, m_fbp;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int par(input int i);
        return (i & 1) ^ ((i >> 1) & 1) ^ ((i >> 2) & 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_bm[i] = 1'b0;
        m_mis = 0; m_cov = 0; m_flag = 0; m_fbv = 0; m_fbp = 0;
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.ld_last     = 1'b0;
        bus.obs_valid   = 1'b0;
        bus.obs_pattern = '0;
        bus.obs_resp    = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld_ready"},  int'(bus.ld_ready),          0);
        chk({tag, "_obs_ready"}, int'(bus.obs_ready),         0);
        chk({tag, "_busy"},      int'(bus.busy),              0);
        chk({tag, "_done"},      int'(bus.done),              0);
        chk({tag, "_flag"},      int'(bus.trojan_flag),       0);
        chk({tag, "_mis"},       int'(bus.mismatch_count),    0);
        chk({tag, "_cov"},       int'(bus.coverage_count),    0);
        chk({tag, "_fbv"},       int'(bus.first_bad_valid),   0);
        chk({tag, "_fbp"},       int'(bus.first_bad_pattern), 0);
    endtask

    task automatic pulse_start();
        @(posedge CK); #1 bus.start = 1'b1;
        @(posedge CK); #1 bus.start = 1'b0;
        model_clear();
    endtask

    task automatic ld_beat(input int a, input int d, input bit last);
        @(posedge CK); #1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = N_IN'(a);
        bus.ld_data  = N_OUT'(d);
        bus.ld_last  = last;
        @(posedge CK); #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        m_tab[a] = d;
    endtask

    task automatic load_parity();
        for (int i = 0; i < 8; i++) ld_beat(i, par(i), i == 7);
    endtask

    // Issue one observe beat and push the response the model predicts for it.
    task automatic obs_beat(input int p, input int r);
        exp_t e;
        if (m_tab[p] != r) begin
            if (m_mis < 15) m_mis++;
            m_flag = 1;
            if (m_fbv == 0) begin
                m_fbv = 1;
                m_fbp = p;
            end
        end
        if (!m_bm[p]) begin
            m_bm[p] = 1'b1;
            m_cov++;
        end
        e.mis = m_mis; e.cov = m_cov; e.flag = m_flag;
        e.fbv = m_fbv; e.fbp = m_fbp; e.done = (m_cov == 8) ? 1 : 0;
        sb.push_back(e);
        @(posedge CK); #1;
        bus.obs_valid   = 1'b1;
        bus.obs_pattern = N_IN'(p);
        bus.obs_resp    = N_OUT'(r);
        @(posedge CK); #1;
        bus.obs_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CK);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: actual %0d pending required 0", sb.size());
        end
    endtask

    // Monitor: a handshake seen at one falling edge is scored at the next one.
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge CK);
            if (pend) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_hs: actual handshake required none");
                end else begin
                    mon_e = sb.pop_front();
                    chk("mon_mis",  int'(bus.mismatch_count),    mon_e.mis);
                    chk("mon_cov",  int'(bus.coverage_count),    mon_e.cov);
                    chk("mon_flag", int'(bus.trojan_flag),       mon_e.flag);
                    chk("mon_fbv",  int'(bus.first_bad_valid),   mon_e.fbv);
                    chk("mon_fbp",  int'(bus.first_bad_pattern), mon_e.fbp);
                    chk("mon_done", int'(bus.done),              mon_e.done);
                end
            end
            pend = bus.obs_valid && bus.obs_ready && reset;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        model_clear();
        reset = 1'b0;
        #12;
        chk_all_zero("reset");
        #5 reset = 1'b1;

        // Golden match, with wrong-phase traffic on both channels.
        pulse_start();
        chk("t1_ld_ready", int'(bus.ld_ready), 1);
        chk("t1_busy",     int'(bus.busy),     1);
        for (int i = 0; i < 7; i++) ld_beat(i, par(i), 1'b0);
        @(posedge CK); #1;
        bus.obs_valid = 1'b1; bus.obs_pattern = 3'd0; bus.obs_resp = 1'b1;
        #1 chk("t1_obs_ready_in_load", int'(bus.obs_ready), 0);
        @(posedge CK); #1 bus.obs_valid = 1'b0;
        chk("t1_cov_after_stray_obs", int'(bus.coverage_count), 0);
        chk("t1_mis_after_stray_obs", int'(bus.mismatch_count), 0);
        ld_beat(7, par(7), 1'b1);
        chk("t1_obs_ready", int'(bus.obs_ready), 1);
        @(posedge CK); #1;
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd0; bus.ld_data = 1'b1; bus.ld_last = 1'b1;
        #1 chk("t1_ld_ready_in_check", int'(bus.ld_ready), 0);
        @(posedge CK); #1 bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("t1_obs_ready_after_stray_ld", int'(bus.obs_ready), 1);
        for (int i = 0; i < 8; i++) obs_beat(i, par(i));
        wait_drain();
        chk("t1_done", int'(bus.done),           1);
        chk("t1_mis",  int'(bus.mismatch_count), 0);
        chk("t1_flag", int'(bus.trojan_flag),    0);
        chk("t1_cov",  int'(bus.coverage_count), 8);
        chk("t1_busy", int'(bus.busy),           0);
        chk("t1_obs_ready_done", int'(bus.obs_ready), 0);

        // Single trojan at pattern 101.
        pulse_start();
        chk("t2_cov_cleared",  int'(bus.coverage_count), 0);
        chk("t2_done_cleared", int'(bus.done),           0);
        load_parity();
        for (int i = 0; i < 8; i++) obs_beat(i, (i == 5) ? 1 - par(i) : par(i));
        wait_drain();
        chk("t2_flag", int'(bus.trojan_flag),       1);
        chk("t2_mis",  int'(bus.mismatch_count),    1);
        chk("t2_fbp",  int'(bus.first_bad_pattern), 5);
        chk("t2_fbv",  int'(bus.first_bad_valid),   1);
        chk("t2_done", int'(bus.done),              1);

        // Duplicates and multiple errors.
        pulse_start();
        chk("t3_flag_cleared", int'(bus.trojan_flag),     0);
        chk("t3_fbv_cleared",  int'(bus.first_bad_valid), 0);
        chk("t3_mis_cleared",  int'(bus.mismatch_count),  0);
        load_parity();
        obs_beat(2, 1 - par(2));
        obs_beat(2, 1 - par(2));
        obs_beat(3, 1 - par(3));
        obs_beat(0, par(0));
        obs_beat(1, par(1));
        obs_beat(4, par(4));
        obs_beat(5, par(5));
        obs_beat(6, par(6));
        chk("t3_not_done_before_9th", int'(bus.done), 0);
        obs_beat(7, par(7));
        wait_drain();
        chk("t3_mis",  int'(bus.mismatch_count),    3);
        chk("t3_fbp",  int'(bus.first_bad_pattern), 2);
        chk("t3_cov",  int'(bus.coverage_count),    8);
        chk("t3_done", int'(bus.done),              1);

        // Reset in the middle of CHECK.
        pulse_start();
        load_parity();
        obs_beat(0, par(0));
        obs_beat(1, 1 - par(1));
        obs_beat(2, par(2));
        obs_beat(3, par(3));
        wait_drain();
        @(negedge CK); #1;
        chk("t5_mis_before_reset", int'(bus.mismatch_count), 1);
        reset = 1'b0;
        #1 chk_all_zero("midreset");
        model_clear();
        @(negedge CK);
        reset = 1'b1;
        pulse_start();
        load_parity();
        for (int i = 0; i < 8; i++) obs_beat(i, par(i));
        wait_drain();
        chk("t5_flag", int'(bus.trojan_flag),    0);
        chk("t5_mis",  int'(bus.mismatch_count), 0);
        chk("t5_done", int'(bus.done),           1);

        // Restart from DONE, rewriting only entry 3.
        pulse_start();
        chk("t6_mis_cleared",  int'(bus.mismatch_count), 0);
        chk("t6_cov_cleared",  int'(bus.coverage_count), 0);
        chk("t6_done_cleared", int'(bus.done),           0);
        ld_beat(3, 1, 1'b1);
        chk("t6_obs_ready", int'(bus.obs_ready), 1);
        for (int i = 0; i < 8; i++) obs_beat(i, (i == 3) ? 1 : par(i));
        wait_drain();
        chk("t6_mis",  int'(bus.mismatch_count), 0);
        chk("t6_cov",  int'(bus.coverage_count), 8);
        chk("t6_done", int'(bus.done),           1);

        @(negedge CK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
